// File: rtl/onehot_drain_encoder_pkg.sv
// Shared definitions for the one-hot drain encoder.
// Contents:
//   WIDTH_DEF, IDX_W_DEF : default request width and index width
//   state_t              : FSM states (IDLE, DRAIN)
//   lowest_set()         : index of the lowest set bit of a WIDTH_DEF vector
//   is_single()          : 1 when exactly one bit of a WIDTH_DEF vector is set
package onehot_drain_encoder_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned IDX_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [IDX_W_DEF-1:0] lowest_set(input logic [WIDTH_DEF-1:0] v);
    logic [IDX_W_DEF-1:0] r;
    logic                 found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH_DEF; i++) begin
      if (v[i] && !found) begin
        r     = IDX_W_DEF'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic is_single(input logic [WIDTH_DEF-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/onehot_drain_encoder_prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   vec    : input vector, bit 0 has the highest priority
//   idx    : index of the lowest set bit (0 when vec is zero)
//   any    : vec != 0
//   single : exactly one bit of vec is set
module prio_enc_lsb #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign any    = |vec;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign single = any && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/onehot_drain_encoder.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index
// of every set bit, lowest first, one per out_valid/out_ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : enable; low blocks acceptance and aborts a drain
//   in_vec, in_valid    : request vector and its valid
//   in_ready            : block can accept a vector
//   out_idx, out_valid  : lowest pending index and its valid
//   out_ready           : consumer accepts out_idx
//   out_last            : out_idx is the final pending bit of the vector
//   busy                : vector held, drain in progress
module onehot_drain_encoder
  import onehot_drain_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [IDX_W-1:0] pidx;
  logic             pany;
  logic             psingle;

  prio_enc_lsb #(.WIDTH(WIDTH)) u_prio (
    .vec    (pend),
    .idx    (pidx),
    .any    (pany),
    .single (psingle)
  );

  // rst_n gates in_ready so it reads low for the whole reset pulse.
  assign in_ready  = rst_n && en && (state == IDLE);
  assign busy      = (state == DRAIN);
  assign out_valid = en && (state == DRAIN);
  assign out_idx   = pidx;
  assign out_last  = psingle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero vector is consumed here without leaving IDLE.
          if (in_valid && in_ready && (in_vec != '0)) begin
            pend  <= in_vec;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!en) begin
            pend  <= '0;
            state <= IDLE;
          end else if (out_ready) begin
            pend <= pend & ~(WIDTH'(1) << pidx);
            if (psingle || !pany) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          pend  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
